// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU.
// Produces one quotient bit per cycle; busy stalls the pipeline and done pulses once when the result is ready.
module seq_divider #(
  parameter int unsigned n = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic         kill,
  input  logic [1:0]   op,
  input  logic [n-1:0] dividend,
  input  logic [n-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [n-1:0] result
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  localparam int unsigned CW = $clog2(n + 1);
  localparam logic [n-1:0] MIN_NEG = {1'b1, {(n-1){1'b0}}};

  state_t         state_q, state_d;
  logic [CW-1:0]  count_q, count_d;
  logic [n-1:0]   rem_q, rem_d;
  logic [n-1:0]   quo_q, quo_d;
  logic [n-1:0]   dvs_q, dvs_d;
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic           sel_rem_q, sel_rem_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [n-1:0]   result_q, result_d;

  logic           a_neg, b_neg, div_zero, overflow;
  logic [n-1:0]   a_mag, b_mag, quo_fix, rem_fix;
  logic [n:0]     rem_sh, trial;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    sel_rem_d = sel_rem_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    result_d  = result_q;

    a_neg    = ~op[0] & dividend[n-1];
    b_neg    = ~op[0] & divisor[n-1];
    a_mag    = a_neg ? ('0 - dividend) : dividend;
    b_mag    = b_neg ? ('0 - divisor) : divisor;
    div_zero = (divisor == '0);
    overflow = ~op[0] & (dividend == MIN_NEG) & (divisor == '1);

    // The shifted remainder is always below 2*divisor, so n+1 bits hold it and the top bit of trial is the borrow.
    rem_sh  = {rem_q, quo_q[n-1]};
    trial   = rem_sh - {1'b0, dvs_q};
    quo_fix = neg_quo_q ? ('0 - quo_q) : quo_q;
    rem_fix = neg_rem_q ? ('0 - rem_q) : rem_q;

    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          sel_rem_d = op[1];
          busy_d    = 1'b1;
          if (div_zero || overflow) begin
            // Special cases preload the final values unsigned and skip the iterations.
            quo_d     = div_zero ? '1 : MIN_NEG;
            rem_d     = div_zero ? dividend : '0;
            neg_quo_d = 1'b0;
            neg_rem_d = 1'b0;
            state_d   = FIX;
          end else begin
            rem_d     = '0;
            quo_d     = a_mag;
            dvs_d     = b_mag;
            neg_quo_d = a_neg ^ b_neg;
            neg_rem_d = a_neg;
            count_d   = CW'(n);
            state_d   = CALC;
          end
        end
      end
      CALC: begin
        if (!trial[n]) begin
          rem_d = trial[n-1:0];
          quo_d = {quo_q[n-2:0], 1'b1};
        end else begin
          rem_d = rem_sh[n-1:0];
          quo_d = {quo_q[n-2:0], 1'b0};
        end
        count_d = count_q - 1'b1;
        if (count_q == CW'(1)) state_d = FIX;
      end
      FIX: begin
        result_d = sel_rem_q ? rem_fix : quo_fix;
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (kill) begin
      state_d  = IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      rem_q     <= '0;
      quo_q     <= '0;
      dvs_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      sel_rem_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      dvs_q     <= dvs_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      sel_rem_q <= sel_rem_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      result_q  <= result_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
